// File: rtl/xspi_retry_ctrl.sv
// ---------------------------------------------------------------------------
// xspi_retry_ctrl
//
// Purpose: sits between a transaction requester and an xSPI master. Each
// accepted request is issued to the master; when an attempt completes with
// a CRC error for that command type, it waits a back-off interval and
// reissues the same command. The outcome of every transaction (ok, ok after
// retry, CRC failure after retries exhausted, timeout) is published as a
// one-cycle done pulse with a transaction record that is held until the
// next completion.
//
// Optional feature: define XSPI_RETRY_STATS_EN to enable the saturating
// stat_retries / stat_failures counters. Without it both are tied to zero
// and the control behaviour is identical.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_cmd/req_addr/req_wdata      request fields (A5 = write, FF = read)
//   mst_start                       one-cycle start pulse to the master
//   mst_command/address/wr_data     latched request driven to the master
//   mst_done, mst_rd_data           attempt completion and read data
//   crc_*_error_*                   CRC flags, valid with mst_done
//   done                            one-cycle completion pulse
//   command/address/wr_data/rd_data final transaction record
//   status                          00 ok, 01 ok after retry,
//                                   10 CRC fail, 11 timeout
//   attempts                        attempts used minus one
//   stat_retries, stat_failures     statistics counters
//
// State | meaning
// IDLE    | ready for a request; latches it into the mst_* outputs
// ISSUE   | one-cycle mst_start, attempt timer cleared
// WAIT    | waiting for mst_done or attempt timeout
// BACKOFF | idle gap before reissuing a failed attempt
// REPORT  | one-cycle done with the updated transaction record
// ---------------------------------------------------------------------------
module xspi_retry_ctrl #(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int BACKOFF_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [47:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        mst_start,
  output logic [7:0]  mst_command,
  output logic [47:0] mst_address,
  output logic [63:0] mst_wr_data,
  input  logic        mst_done,
  input  logic [63:0] mst_rd_data,
  input  logic        crc_ca_error_slave,
  input  logic        crc_data_error_slave,
  input  logic        crc_ca_error_master,
  input  logic        crc_data_error_master,
  output logic        done,
  output logic [7:0]  command,
  output logic [47:0] address,
  output logic [63:0] wr_data,
  output logic [63:0] rd_data,
  output logic [1:0]  status,
  output logic [2:0]  attempts,
  output logic [15:0] stat_retries,
  output logic [15:0] stat_failures
);

  // Timer counts 0 .. TIMEOUT_CYCLES-1, one value per WAIT cycle.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  // Back-off is a down-counter loaded on entry; terminal count 0 ends it.
  localparam logic [7:0]    BO_LOAD  = 8'(BACKOFF_CYCLES - 1);
  localparam logic [2:0]    ATT_MAX  = 3'(MAX_RETRY);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_OK_RETRY = 2'b01;
  localparam logic [1:0] ST_CRC_FAIL = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    BACKOFF = 3'd3,
    REPORT  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [7:0]    bo_cnt;
  logic [2:0]    att;

  logic          attempt_err;
  logic          rpt_load;
  logic          rpt_timeout;
  logic [1:0]    rpt_status;
  logic          bo_enter;

  // Which CRC flags matter depends on the data direction of the command.
  always_comb begin
    attempt_err = 1'b0;
    case (mst_command)
      8'hA5:   attempt_err = crc_ca_error_slave | crc_data_error_slave;
      8'hFF:   attempt_err = crc_ca_error_slave | crc_data_error_master;
      default: attempt_err = crc_ca_error_slave | crc_ca_error_master;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    mst_start   = 1'b0;
    done        = 1'b0;
    rpt_load    = 1'b0;
    rpt_timeout = 1'b0;
    rpt_status  = ST_OK;
    bo_enter    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so every output reads 0 while reset is held.
        req_ready = rst_n;
        if (req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        mst_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // mst_done wins over a timer expiry in the same cycle.
        if (mst_done) begin
          if (!attempt_err) begin
            rpt_load   = 1'b1;
            rpt_status = (att == 3'd0) ? ST_OK : ST_OK_RETRY;
            state_nxt  = REPORT;
          end else if (att < ATT_MAX) begin
            bo_enter  = 1'b1;
            state_nxt = BACKOFF;
          end else begin
            rpt_load   = 1'b1;
            rpt_status = ST_CRC_FAIL;
            state_nxt  = REPORT;
          end
        end else if (timer == TMR_LAST) begin
          rpt_load    = 1'b1;
          rpt_timeout = 1'b1;
          rpt_status  = ST_TIMEOUT;
          state_nxt   = REPORT;
        end
      end
      BACKOFF: begin
        if (bo_cnt == 8'd0) state_nxt = ISSUE;
      end
      REPORT: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_command <= '0;
      mst_address <= '0;
      mst_wr_data <= '0;
      att         <= '0;
      timer       <= '0;
      bo_cnt      <= '0;
      command     <= '0;
      address     <= '0;
      wr_data     <= '0;
      rd_data     <= '0;
      status      <= '0;
      attempts    <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        mst_command <= req_cmd;
        mst_address <= req_addr;
        mst_wr_data <= req_wdata;
        att         <= '0;
      end

      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;

      if (bo_enter) begin
        att    <= att + 3'd1;
        bo_cnt <= BO_LOAD;
      end else if (state == BACKOFF && bo_cnt != 8'd0) begin
        bo_cnt <= bo_cnt - 8'd1;
      end

      // Record is written on the edge into REPORT so it is visible with done.
      if (rpt_load) begin
        command  <= mst_command;
        address  <= mst_address;
        wr_data  <= mst_wr_data;
        rd_data  <= rpt_timeout ? 64'd0 : mst_rd_data;
        status   <= rpt_status;
        attempts <= att;
      end
    end
  end

`ifdef XSPI_RETRY_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_retries  <= '0;
      stat_failures <= '0;
    end else begin
      if (bo_enter && stat_retries != 16'hFFFF)
        stat_retries <= stat_retries + 16'd1;
      if (rpt_load && rpt_status[1] && stat_failures != 16'hFFFF)
        stat_failures <= stat_failures + 16'd1;
    end
  end
`else
  assign stat_retries  = 16'd0;
  assign stat_failures = 16'd0;
`endif

endmodule

// File: tb/tb_xspi_retry_ctrl.sv
module tb_xspi_retry_ctrl;

  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 16;
  localparam int BACKOFF   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = '0;
  logic [47:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        mst_start;
  logic [7:0]  mst_command;
  logic [47:0] mst_address;
  logic [63:0] mst_wr_data;
  logic        mst_done = 1'b0;
  logic [63:0] mst_rd_data = '0;
  logic        crc_ca_error_slave = 1'b0;
  logic        crc_data_error_slave = 1'b0;
  logic        crc_ca_error_master = 1'b0;
  logic        crc_data_error_master = 1'b0;
  logic        done;
  logic [7:0]  command;
  logic [47:0] address;
  logic [63:0] wr_data;
  logic [63:0] rd_data;
  logic [1:0]  status;
  logic [2:0]  attempts;
  logic [15:0] stat_retries;
  logic [15:0] stat_failures;

  xspi_retry_ctrl #(
    .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYCLES(TIMEOUT), .BACKOFF_CYCLES(BACKOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .mst_start(mst_start), .mst_command(mst_command),
    .mst_address(mst_address), .mst_wr_data(mst_wr_data),
    .mst_done(mst_done), .mst_rd_data(mst_rd_data),
    .crc_ca_error_slave(crc_ca_error_slave),
    .crc_data_error_slave(crc_data_error_slave),
    .crc_ca_error_master(crc_ca_error_master),
    .crc_data_error_master(crc_data_error_master),
    .done(done), .command(command), .address(address),
    .wr_data(wr_data), .rd_data(rd_data), .status(status),
    .attempts(attempts),
    .stat_retries(stat_retries), .stat_failures(stat_failures)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Master behaviour per attempt: response delay in WAIT cycles (>= TIMEOUT
  // means no response), CRC flags {ca_s, data_s, ca_m, data_m}, read data.
  int          plan_delay[8];
  logic [3:0]  plan_flags[8];
  logic [63:0] plan_rd[8];

  int exp_retries = 0;
  int exp_failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mst_done = 1'b0;
    {crc_ca_error_slave, crc_data_error_slave,
     crc_ca_error_master, crc_data_error_master} = 4'b0000;
  endtask

  task automatic drive_resp(input logic [3:0] flags, input logic [63:0] rd);
    mst_done = 1'b1;
    {crc_ca_error_slave, crc_data_error_slave,
     crc_ca_error_master, crc_data_error_master} = flags;
    mst_rd_data = rd;
  endtask

  function automatic bit crc_err(input logic [7:0] cmd, input logic [3:0] f);
    if (cmd == 8'hA5)      return f[3] | f[2];
    else if (cmd == 8'hFF) return f[3] | f[0];
    else                   return f[3] | f[1];
  endfunction

  task automatic check_stats(input string tag);
`ifdef XSPI_RETRY_STATS_EN
    check_val({tag, "_stat_retries"},  stat_retries,  exp_retries);
    check_val({tag, "_stat_failures"}, stat_failures, exp_failures);
`else
    check_val({tag, "_stats_tied"}, {stat_retries, stat_failures}, 0);
`endif
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [47:0] addr,
                         input logic [63:0] wdata);
    int exp_status, exp_att, exp_done, a, sched, last_done, nstart;
    logic [63:0] exp_rd;
    bit fin, got;

    // Outcome from the retry rules, one attempt at a time.
    exp_status = -1;
    exp_att    = 0;
    exp_rd     = '0;
    for (int i = 0; i <= MAX_RETRY && exp_status < 0; i++) begin
      if (plan_delay[i] >= TIMEOUT) begin
        exp_status = 3; exp_att = i; exp_rd = '0;
      end else if (!crc_err(cmd, plan_flags[i])) begin
        exp_status = (i == 0) ? 0 : 1; exp_att = i; exp_rd = plan_rd[i];
      end else if (i == MAX_RETRY) begin
        exp_status = 2; exp_att = i; exp_rd = plan_rd[i];
      end
    end
    exp_retries  += exp_att;
    exp_failures += (exp_status >= 2) ? 1 : 0;

    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    req_wdata = wdata;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      if (req_ready) got = 1;
      else tick();
    end
    check_val("accept_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_cmd   = $urandom;
    check_val("start_latency", mst_start, 1);

    a = 0; sched = -1; last_done = -1; nstart = 0; exp_done = -1; fin = 0;
    for (int n = 0; n < 300 && !fin; n++) begin
      if (n > 0) tick();
      check_val("busy_ready", req_ready, 0);
      if (mst_start) begin
        nstart++;
        if (a > 0) check_val("backoff_gap", cyc - last_done, BACKOFF + 1);
        check_val("mst_command", mst_command, cmd);
        check_val("mst_address", mst_address, addr);
        check_val("mst_wr_data", mst_wr_data, wdata);
        if (a == exp_att)
          exp_done = (plan_delay[a] >= TIMEOUT) ? cyc + 1 + TIMEOUT
                                                : cyc + plan_delay[a] + 2;
        sched = (plan_delay[a] < TIMEOUT) ? cyc + 1 + plan_delay[a] : -1;
      end else if (cyc == sched) begin
        drive_resp(plan_flags[a], plan_rd[a]);
        last_done = cyc;
        sched = -1;
        a++;
      end else if (last_done >= 0 && cyc == last_done + 2 && a <= exp_att) begin
        // Stray completion during back-off must be ignored.
        drive_resp(4'b0000, {$urandom, $urandom});
      end
      if (done) begin
        fin = 1;
        check_val("done_time", cyc, exp_done);
        check_val("status", status, exp_status);
        check_val("attempts", attempts, exp_att);
        check_val("starts", nstart, exp_att + 1);
        check_val("rec_command", command, cmd);
        check_val("rec_address", address, addr);
        check_val("rec_wr_data", wr_data, wdata);
        check_val("rec_rd_data", rd_data, exp_rd);
        check_stats("report");
      end
    end
    check_val("done_seen", fin, 1);

    tick();
    check_val("done_single", done, 0);
    check_val("idle_ready", req_ready, 1);
    drive_resp(4'b1111, {$urandom, $urandom});
    tick();
    check_val("idle_ignore_start", {mst_start, done}, 0);
    tick();
    check_val("idle_ignore_done", done, 0);
    check_val("hold_status", status, exp_status);
    check_val("hold_rd_data", rd_data, exp_rd);
  endtask

  task automatic clean_plan();
    for (int i = 0; i < 8; i++) begin
      plan_delay[i] = 2;
      plan_flags[i] = 4'b0000;
      plan_rd[i]    = {$urandom, $urandom};
    end
  endtask

  task automatic reset_midflight();
    bit seen;
    req_valid = 1'b1;
    req_cmd   = 8'hA5;
    req_addr  = 48'h0000_0000_2000;
    req_wdata = 64'hDEAD_BEEF_0000_0001;
    check_val("rst_pre_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check_val("rst_first_start", mst_start, 1);
    tick();
    drive_resp(4'b0100, {$urandom, $urandom});
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (mst_start) seen = 1;
    end
    check_val("rst_second_start", seen, 1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_val("rst_ctl", {done, req_ready, mst_start, status, attempts}, 0);
    check_val("rst_mst_cmd_addr", {mst_command, mst_address}, 0);
    check_val("rst_mst_wdata", mst_wr_data, 0);
    check_val("rst_rec_cmd_addr", {command, address}, 0);
    check_val("rst_rec_wdata", wr_data, 0);
    check_val("rst_rec_rdata", rd_data, 0);
    check_val("rst_stats", {stat_retries, stat_failures}, 0);
    exp_retries  = 0;
    exp_failures = 0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_val("rst_release_ready", req_ready, 1);
    drive_resp(4'b0000, {$urandom, $urandom});
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (done || mst_start) seen = 1;
    end
    check_val("rst_late_done_ignored", seen, 0);
    clean_plan();
    run_txn(8'hA5, 48'h0000_0000_3000, 64'h0123_4567_89AB_CDEF);
  endtask

  initial begin
    logic [7:0] rcmd;
    #1;
    check_val("reset_ctl", {done, req_ready, mst_start, status, attempts}, 0);
    check_val("reset_rec", {command, address}, 0);
    check_stats("reset");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_val("release_ready", req_ready, 1);

    // CRC failure on every write attempt: retries exhausted.
    clean_plan();
    for (int i = 0; i < 4; i++) plan_flags[i] = 4'b0100;
    run_txn(8'hA5, 48'h0000_0000_1000, 64'h1122_3344_5566_7788);

    // Clean write, first try.
    clean_plan();
    plan_delay[0] = 3;
    run_txn(8'hA5, 48'h0000_0000_1000, 64'h1122_3344_5566_7788);

    // Read that needs two retries.
    clean_plan();
    plan_flags[0] = 4'b0001; plan_delay[0] = 2;
    plan_flags[1] = 4'b0001; plan_delay[1] = 5;
    plan_flags[2] = 4'b0000; plan_delay[2] = 1;
    run_txn(8'hFF, 48'h0000_0000_1008, 64'h0);

    // No response: timeout, never retried.
    clean_plan();
    plan_delay[0] = TIMEOUT;
    run_txn(8'hFF, 48'h0000_0000_1010, 64'h0);

    // Completion in the very last WAIT cycle beats the timeout.
    clean_plan();
    plan_delay[0] = TIMEOUT - 1;
    run_txn(8'h3C, 48'h0000_0000_1018, 64'h5A5A);

    // Flags irrelevant to the command type do not cause a retry.
    clean_plan();
    plan_flags[0] = 4'b0011;
    run_txn(8'hA5, 48'h0000_0000_1020, 64'h77);

    reset_midflight();

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) begin
        plan_delay[i] = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                                    : int'($urandom_range(0, TIMEOUT - 1));
        plan_flags[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
        plan_rd[i]    = {$urandom, $urandom};
      end
      case ($urandom_range(0, 2))
        0:       rcmd = 8'hA5;
        1:       rcmd = 8'hFF;
        default: rcmd = 8'($urandom);
      endcase
      run_txn(rcmd, {16'($urandom), 32'($urandom)}, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xspi_retry_ctrl.md
XSPI_RETRY_CTRL -- requirements
Module: xspi_retry_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: retries allowed after the first attempt (range 0..7).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum WAIT cycles per attempt.
REQ-003 SHALL have parameter BACKOFF_CYCLES, default 4: idle cycles between a failed attempt and its reissue (range 1..255).
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  transaction request.
- req_ready  out  1  request accepted when high with req_valid.
- req_cmd  in  8  command; A5 = write, FF = read.
- req_addr  in  48  address.
- req_wdata  in  64  write data.
- mst_start  out  1  one-cycle start pulse to the xSPI master.
- mst_command  out  8  command to the master.
- mst_address  out  48  address to the master.
- mst_wr_data  out  64  write data to the master.
- mst_done  in  1  one-cycle attempt-complete pulse from the master.
- mst_rd_data  in  64  read data from the master, valid with mst_done.
- crc_ca_error_slave, crc_data_error_slave, crc_ca_error_master, crc_data_error_master  in  1 each  CRC error flags, valid with mst_done.
- done  out  1  one-cycle completion pulse to the monitor.
- command, address, wr_data, rd_data  out  8/48/64/64  final transaction record.
- status  out  2  00 = ok first try, 01 = ok after retry, 10 = CRC fail after retries exhausted, 11 = timeout.
- attempts  out  3  attempts used minus 1.
- stat_retries, stat_failures  out  16 each  statistics counters.

Function
REQ-005 SHALL use FSM states IDLE, ISSUE, WAIT, BACKOFF, REPORT.
REQ-006 IDLE:
- req_ready=1.
- On req_valid, SHALL latch cmd/addr/wdata into mst_* outputs, clear the attempt counter, and go to ISSUE.
REQ-007 req_ready SHALL be 0 in all states other than IDLE; requests there are held off, not dropped.
REQ-008 ISSUE: mst_start=1 for exactly one cycle, timer cleared; next state WAIT.
REQ-009 WAIT: timer increments each cycle; mst_done SHALL be sampled, with the CRC flags and mst_rd_data, in the cycle it is high.
REQ-010 The error condition SHALL be:
- cmd A5: crc_ca_error_slave | crc_data_error_slave.
- cmd FF: crc_ca_error_slave | crc_data_error_master.
- other commands: crc_ca_error_slave | crc_ca_error_master.
REQ-011 In WAIT on mst_done:
- no error -> REPORT, status 00 if attempts==0, else 01.
- error and attempts<MAX_RETRY -> increment attempts, go to BACKOFF.
- error and attempts==MAX_RETRY -> REPORT, status 10.
REQ-012 When the timer reaches TIMEOUT_CYCLES without mst_done, SHALL go to REPORT with status 11; timeouts SHALL NOT be retried.
REQ-013 If mst_done and timer expiry occur in the same cycle, mst_done SHALL take priority.
REQ-014 mst_done outside WAIT SHALL be ignored.
REQ-015 BACKOFF: count BACKOFF_CYCLES cycles, then go to ISSUE with mst_* unchanged.
REQ-016 REPORT: done=1 for one cycle; command/address/wr_data/rd_data/status/attempts SHALL be updated in the same cycle and held until the next REPORT; next state IDLE.
REQ-017 rd_data SHALL come from the last sampled mst_rd_data; it SHALL be 0 on timeout.
REQ-018 Minimum latency: accept edge -> mst_start next cycle; done asserts the cycle after the mst_done sample.

Reset
REQ-019 While rst_n=0, all outputs and counters SHALL be 0, the FSM SHALL be in IDLE, and mst_start SHALL be 0, regardless of the transaction in flight.
REQ-020 After reset release, the first cycle SHALL show req_ready=1.

Configuration
REQ-021 Macro XSPI_RETRY_STATS_EN, when defined, SHALL enable two 16-bit counters:
- stat_retries: +1 per BACKOFF entry.
- stat_failures: +1 per REPORT with status 10 or 11.
- Both saturate at FFFF.
REQ-022 When XSPI_RETRY_STATS_EN is undefined, stat_retries and stat_failures SHALL be tied to 0 and the FSM behaviour SHALL be unchanged.

Verification
REQ-023 Write A5, addr 000000001000, data 1122334455667788, no CRC errors -> one mst_start; done with status 00, attempts 0, wr_data 1122334455667788.
REQ-024 Read FF, crc_data_error_master=1 on the first two mst_done pulses, clear on the third -> three mst_start pulses, each spaced 4+ idle cycles after the previous mst_done; status 01, attempts 2.
REQ-025 Write A5 with crc_data_error_slave=1 on every attempt, MAX_RETRY=3 -> 4 mst_start pulses; status 10, attempts 3; with XSPI_RETRY_STATS_EN, stat_retries=3 and stat_failures=1.
REQ-026 No mst_done, TIMEOUT_CYCLES=16 -> done 16 cycles after WAIT entry; status 11, rd_data 0; single mst_start.
REQ-027 rst_n low during WAIT of the second attempt -> all outputs 0 immediately; mst_done arriving afterwards produces no done; next request completes with status 00.
